// File: rtl/mobo_mem_responder.sv
// Motherboard-side responder for the CPU ctrl/stat four-phase handshake.
// Requests are latched in IDLE, held in BUSY for LATENCY cycles, then serviced
// against a word-addressed memory; progress is reported on mobo_stat.
module mobo_mem_responder #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] mobo_ctrl,
  output logic [WORD_WIDTH-1:0] mobo_stat,
  input  logic [WORD_WIDTH-1:0] addr_in,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [WORD_WIDTH-1:0] CtrlNone  = WORD_WIDTH'(0);
  localparam logic [WORD_WIDTH-1:0] CtrlRead  = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] CtrlWrite = WORD_WIDTH'(2);

  // Encodings double as the STAT_* codes driven on mobo_stat.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2,
    StErr  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [WORD_WIDTH-1:0] data_out_q, data_out_d;
  logic                  mem_we;
  logic                  addr_ok;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Full-width unsigned compare; the extra bit keeps DEPTH from truncating.
  assign addr_ok = ({1'b0, addr_q} < (WORD_WIDTH + 1)'(DEPTH));

  // Next-state, request latching and access decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    data_out_d = data_out_q;
    mem_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mobo_ctrl == CtrlRead || mobo_ctrl == CtrlWrite) begin
          addr_d  = addr_in;
          wdata_d = data_in;
          wr_d    = (mobo_ctrl == CtrlWrite);
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StBusy;
        end else if (mobo_ctrl != CtrlNone) begin
          state_d = StErr;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          if (addr_ok) begin
            state_d = StDone;
            if (wr_q) begin
              mem_we = 1'b1;
            end else begin
              data_out_d = mem[addr_q[IdxW-1:0]];
            end
          end else begin
            state_d = StErr;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone, StErr: begin
        if (mobo_ctrl == CtrlNone) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and request registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      data_out_q <= data_out_d;
    end
  end

  // Memory array is not reset; a reset edge suppresses a pending write.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[addr_q[IdxW-1:0]] <= wdata_q;
    end
  end

  assign mobo_stat = {{(WORD_WIDTH - 2){1'b0}}, state_q};
  assign data_out  = data_out_q;

endmodule

// File: doc/mobo_mem_responder.md
# mobo_mem_responder

Responder (target) end of the motherboard ctrl/stat handshake that the CPU drives as initiator. It accepts read and write requests on `mobo_ctrl`, with the address and write data presented alongside. It services each request against an internal word-addressed memory after a programmable latency and reports progress on `mobo_stat`. It sits on the motherboard side, directly facing the CPU's `addr_out`, `mobodat_out` and `mobodat_in` registers.

## Interface
- `WORD_WIDTH`, 32: width of the ctrl, stat, address and data words.
- `DEPTH`, 256: number of memory words. Valid addresses are 0..DEPTH-1.
- `LATENCY`, 2: cycles spent in BUSY per request. Must be ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `mobo_ctrl`  in  WORD_WIDTH  request code: CTRL_NONE=0, CTRL_READ=1, CTRL_WRITE=2. Any other value is illegal.
- `mobo_stat`  out  WORD_WIDTH  status code, registered: STAT_IDLE=0, STAT_BUSY=1, STAT_DONE=2, STAT_ERR=3.
- `addr_in`  in  WORD_WIDTH  request address (CPU `addr_out`).
- `data_in`  in  WORD_WIDTH  write data (CPU `mobodat_out`).
- `data_out`  out  WORD_WIDTH  read data (to CPU `mobodat_in`), registered.

## Operation
- FSM states: IDLE, BUSY, DONE, ERR. `mobo_stat` always encodes the current state.
- Handshake is four-phase:
  - initiator waits for STAT_IDLE, then raises READ or WRITE;
  - responder runs BUSY, then reports DONE or ERR;
  - initiator returns `mobo_ctrl` to CTRL_NONE;
  - responder returns to IDLE.
- IDLE:
  - samples `mobo_ctrl` every cycle.
  - On READ or WRITE: latch `addr_in`, `data_in` and the opcode, load the latency counter with LATENCY-1, go to BUSY.
  - On NONE: stay in IDLE.
  - On an illegal code: go to ERR.
- BUSY:
  - the counter decrements each cycle.
  - Changes on `mobo_ctrl`, `addr_in` and `data_in` are ignored; the latched request always completes and no abort is supported.
  - When the counter reaches 0:
    - latched address < DEPTH: perform the access and go to DONE.
    - otherwise: no memory access and `data_out` is unchanged; go to ERR.
- Access on the BUSY→DONE edge:
  - write: `mem[addr] <= data`.
  - read: `data_out <= mem[addr]`.
- DONE and ERR are held while `mobo_ctrl` ≠ CTRL_NONE. Once `mobo_ctrl` = CTRL_NONE is sampled, go to IDLE.
- `data_out` holds its value until the next successful read completes. Writes do not affect `data_out`.
- Address compare uses the full WORD_WIDTH latched address, unsigned. There is no wrap-around or truncation.

## Timing
- Reset (`rst`=0 at an edge):
  - state IDLE, `mobo_stat`=STAT_IDLE, `data_out`=0, counter=0, latched request cleared.
  - Memory contents are not reset.
  - Reset mid-BUSY discards the request, so a write is never committed.
- A request sampled in IDLE at edge N gives:
  - `mobo_stat`=BUSY for cycles N+1..N+LATENCY;
  - DONE/ERR from N+LATENCY+1, with read data valid on `data_out` in the same cycle as DONE.
- With LATENCY=1, BUSY lasts exactly one cycle.
- If the initiator already drove NONE during BUSY, DONE/ERR lasts exactly one cycle, then IDLE.
- If NONE is sampled at edge M while in DONE/ERR, IDLE is shown from M+1. A new request sampled at M+1 is accepted, so back-to-back requests cost a minimum of LATENCY+2 cycles each.
- A request present at the same edge as the DONE→IDLE transition is not accepted, because the request code is not NONE. The four-phase handshake guarantees this case does not occur.

## Test plan
- Reset, then WRITE addr=5 data=0xA5, LATENCY=2:
  - stat goes IDLE, BUSY, BUSY, DONE;
  - drop ctrl to NONE → IDLE one cycle later;
  - then READ addr=5 → DONE with `data_out`=0xA5.
- READ addr=256 (DEPTH=256) → ERR after 2 BUSY cycles; `data_out` keeps its prior value; ERR holds until ctrl=NONE. WRITE addr=300 → ERR, and a later read of every address shows no change.
- During BUSY of WRITE addr=7 data=0x11, change `addr_in` to 8, `data_in` to 0x22 and ctrl to READ → mem[7]=0x11, mem[8] unchanged.
- ctrl=3 in IDLE → ERR next cycle; ctrl=NONE → IDLE.
- Assert `rst`=0 in the second BUSY cycle of WRITE addr=9 data=0x33 → stat IDLE and `data_out`=0 after the edge; a later read of addr 9 returns its old value, not 0x33.
- Back-to-back READ addr 1 then READ addr 2, with the initiator dropping ctrl the cycle after DONE → second request accepted on the first IDLE cycle; total 8 cycles at LATENCY=2.
